// File: rtl/rooth_defines.sv
// Shared definitions for the rooth core pipeline control: flow codes,
// datapath widths and the flow controller's FSM state encodings.
package rooth_defines;

    localparam int CPU_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int FLOW_WIDTH     = 2;
    localparam int CNT_WIDTH      = 32;

    // Per-stage flow code; 2'b11 is never driven.
    typedef enum logic [FLOW_WIDTH-1:0] {
        FLOW_WORK    = 2'b00,
        FLOW_STOP    = 2'b01,
        FLOW_REFRESH = 2'b10
    } flow_e;

    // Interrupt-entry FSM of the flow controller.
    typedef enum logic [1:0] {
        FC_RUN      = 2'd0,
        FC_INT_WAIT = 2'd1,
        FC_INT_TAKE = 2'd2
    } fc_state_e;

endpackage

// File: rtl/flow_hazard_det.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// being loaded by the instruction currently in EX. x0 never creates a hazard.
module flow_hazard_det
    import rooth_defines::*;
(
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
    input  logic                      ex_mem_rd_i,
    output logic                      load_use_o
);

    // Compare the EX load destination against each source the ID instr reads.
    always_comb begin
        load_use_o = ex_mem_rd_i && (ex_rd_i != '0) &&
                     ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                      (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
    end

endmodule

// File: rtl/flow_ctrl.sv
// Central pipeline flow controller. Produces the per-stage flow codes and PC
// redirect combinationally from the current hazards and the interrupt FSM
// state, and counts the cycles in which the PC register is stopped.
//
// Handshake: int_req_i is a level held by the requester until int_ack_o
// pulses for one cycle; the ack cycle is also the cycle the PC is loaded with
// int_vec_i. No other valid/ready pairs exist on this block.
module flow_ctrl
    import rooth_defines::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_reg1_rd_adder_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_reg2_rd_adder_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_adder_i,
    input  logic                      ex_mem_rd_i,
    input  logic                      ex_busy_i,
    input  logic                      mem_busy_i,
    input  logic                      ex_redirect_i,
    input  logic [CPU_WIDTH-1:0]      ex_redirect_pc_i,
    input  logic                      int_req_i,
    input  logic [CPU_WIDTH-1:0]      int_vec_i,
    output logic [FLOW_WIDTH-1:0]     flow_pc_o,
    output logic [FLOW_WIDTH-1:0]     flow_if_id_o,
    output logic [FLOW_WIDTH-1:0]     flow_ex_o,
    output logic [FLOW_WIDTH-1:0]     flow_mem_o,
    output logic                      pc_redirect_en_o,
    output logic [CPU_WIDTH-1:0]      pc_redirect_o,
    output logic                      int_ack_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

    logic                 load_use;
    fc_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    flow_e                flow_pc, flow_if_id, flow_ex, flow_mem;
    logic                 stalled;

    flow_hazard_det u_hazard (
        .id_rs1_i      (id_reg1_rd_adder_i),
        .id_rs2_i      (id_reg2_rd_adder_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .ex_rd_i       (ex_reg_wr_adder_i),
        .ex_mem_rd_i   (ex_mem_rd_i),
        .load_use_o    (load_use)
    );

    // A multi-cycle EX op or memory wait freezes everything, interrupts included.
    assign stalled = mem_busy_i || ex_busy_i;

    // Priority mux: stalls, then interrupt entry, then EX redirect, then load-use.
    always_comb begin
        flow_pc          = FLOW_WORK;
        flow_if_id       = FLOW_WORK;
        flow_ex          = FLOW_WORK;
        flow_mem         = FLOW_WORK;
        pc_redirect_en_o = 1'b0;
        pc_redirect_o    = '0;
        int_ack_o        = 1'b0;
        if (rst) begin
            flow_pc    = FLOW_REFRESH;
            flow_if_id = FLOW_REFRESH;
            flow_ex    = FLOW_REFRESH;
            flow_mem   = FLOW_REFRESH;
        end else if (mem_busy_i) begin
            flow_pc    = FLOW_STOP;
            flow_if_id = FLOW_STOP;
            flow_ex    = FLOW_STOP;
            flow_mem   = FLOW_STOP;
        end else if (ex_busy_i) begin
            // The op in EX is still running, so any redirect it shows is not final.
            flow_pc    = FLOW_STOP;
            flow_if_id = FLOW_STOP;
            flow_ex    = FLOW_STOP;
            flow_mem   = FLOW_REFRESH;
        end else if (state_q == FC_INT_TAKE) begin
            flow_if_id       = FLOW_REFRESH;
            flow_ex          = FLOW_REFRESH;
            pc_redirect_en_o = 1'b1;
            pc_redirect_o    = int_vec_i;
            int_ack_o        = 1'b1;
        end else if (ex_redirect_i) begin
            // Flushing ID also removes any load-use hazard it carried.
            flow_if_id       = FLOW_REFRESH;
            flow_ex          = FLOW_REFRESH;
            pc_redirect_en_o = 1'b1;
            pc_redirect_o    = ex_redirect_pc_i;
        end else if (load_use) begin
            flow_pc    = FLOW_STOP;
            flow_if_id = FLOW_STOP;
            flow_ex    = FLOW_REFRESH;
        end
    end

    assign flow_pc_o    = flow_pc;
    assign flow_if_id_o = flow_if_id;
    assign flow_ex_o    = flow_ex;
    assign flow_mem_o   = flow_mem;

    // Interrupt FSM next state: wait for a clean slot, take it for one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FC_RUN: begin
                if (int_req_i) state_d = FC_INT_WAIT;
            end
            FC_INT_WAIT: begin
                if (!stalled && !ex_redirect_i) state_d = FC_INT_TAKE;
            end
            FC_INT_TAKE: begin
                if (!stalled) state_d = FC_RUN;
            end
            default: state_d = FC_RUN;
        endcase
    end

    // Saturating count of cycles in which the PC register is held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((flow_pc == FLOW_STOP) && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    // State and counter registers; reset drops any pending interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FC_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
